// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions for the MAC unit and the divider.
// Contents: operand width, 16-bit signed limits and the MAC state encoding.
package arith_pkg;

  localparam int unsigned ARITH_WIDTH = 16;

  localparam logic [15:0] S16_MAX = 16'h7FFF;
  localparam logic [15:0] S16_MIN = 16'h8000;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFinish
  } mac_state_t;

endpackage

// File: rtl/mac_unit_if.sv
// Handshake and operand/result bundle of the MAC unit.
// master: requester (drives start and operands, observes status and results).
// slave:  the MAC unit itself.
interface mac_unit_if #(
  parameter int unsigned WIDTH = arith_pkg::ARITH_WIDTH
) ();

  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     addend;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     result16;
  logic                 overflow;

  modport master (
    output start, multiplicand, multiplier, addend,
    input  busy, done, result, result16, overflow
  );

  modport slave (
    input  start, multiplicand, multiplier, addend,
    output busy, done, result, result16, overflow
  );

endinterface

// File: rtl/sat_narrow.sv
// Combinational 2*WIDTH -> WIDTH narrower for the MAC result.
// Macro MAC_SAT_EN: when defined, an out-of-range value saturates to the signed
// WIDTH-bit limit of the same sign; otherwise the low WIDTH bits pass through.
// Ports: wide_i (full-precision signed value), narrow_o (narrowed value),
//        overflow_o (wide_i not representable in WIDTH signed bits).
module sat_narrow #(
  parameter int unsigned WIDTH = arith_pkg::ARITH_WIDTH
) (
  input  logic [2*WIDTH-1:0] wide_i,
  output logic [WIDTH-1:0]   narrow_o,
  output logic               overflow_o
);

  always_comb begin
    overflow_o = (wide_i != {{WIDTH{wide_i[WIDTH-1]}}, wide_i[WIDTH-1:0]});
`ifdef MAC_SAT_EN
    if (overflow_o) begin
      narrow_o = wide_i[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      narrow_o = wide_i[WIDTH-1:0];
    end
`else
    narrow_o = wide_i[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/mac_unit.sv
// Sequential signed multiply-accumulate: result = multiplicand * multiplier + addend.
// Radix-2 shift-add on operand magnitudes, sign applied at the end; one result every
// WIDTH+2 cycles. Optional saturation of result16 under macro MAC_SAT_EN (see sat_narrow).
// Ports: clk, rst (synchronous, active-high), bus (mac_unit_if.slave: start, operands,
//        busy, done pulse, result, result16, overflow).
module mac_unit #(
  parameter int unsigned WIDTH = arith_pkg::ARITH_WIDTH
) (
  input logic       clk,
  input logic       rst,
  mac_unit_if.slave bus
);
  import arith_pkg::*;

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  mac_state_t         state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   addend_q, addend_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0]   result16_q, result16_d;
  logic               overflow_q, overflow_d;

  // One extra bit so that the most negative operand has a representable magnitude.
  logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
  logic [2*WIDTH-1:0] signed_prod, fin_sum;
  logic [WIDTH-1:0]   fin_narrow;
  logic               fin_ovf;

  always_comb begin
    a_ext       = {bus.multiplicand[WIDTH-1], bus.multiplicand};
    b_ext       = {bus.multiplier[WIDTH-1], bus.multiplier};
    a_mag       = a_ext[WIDTH] ? -a_ext : a_ext;
    b_mag       = b_ext[WIDTH] ? -b_ext : b_ext;
    signed_prod = sign_q ? -acc_q : acc_q;
    // Bounded by 2^30 + 2^15 in magnitude, so this add never wraps.
    fin_sum     = signed_prod + {{WIDTH{addend_q[WIDTH-1]}}, addend_q};
  end

  sat_narrow #(
    .WIDTH (WIDTH)
  ) u_sat_narrow (
    .wide_i     (fin_sum),
    .narrow_o   (fin_narrow),
    .overflow_o (fin_ovf)
  );

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    sign_d     = sign_q;
    addend_d   = addend_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    result16_d = result16_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mcand_d  = {{(WIDTH-1){1'b0}}, a_mag};
          mplier_d = b_mag;
          sign_d   = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
          addend_d = bus.addend;
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CntW'(1);
        // WIDTH+1 iterations cover every bit of the (WIDTH+1)-bit magnitude.
        if (count_q == CntW'(WIDTH)) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        result_d   = fin_sum;
        result16_d = fin_narrow;
        overflow_d = fin_ovf;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      sign_q     <= 1'b0;
      addend_q   <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      result16_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      sign_q     <= sign_d;
      addend_q   <= addend_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      result16_q <= result16_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.result16 = result16_q;
  assign bus.overflow = overflow_q;

endmodule
